// File: rtl/fxp_requant_if.sv
// Stream bundle for the requantizer: accumulator words in, saturated OUT_W-bit results out.
interface fxp_requant_if #(
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [31:0]      in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fxp_requant_ctrl.sv
// Per-channel requantizer: table lookup on accept, multiply, round-shift + saturate, output register.
// Single global stall: every stage moves only when the output register can move.
module fxp_requant_ctrl #(
  parameter int N_CH    = 16,
  parameter int OUT_W   = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(N_CH)-1:0]  cfg_ch,
  input  logic signed [MULT_W-1:0] cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  output logic                     cfg_err,
  fxp_requant_if.slave             bus,
  output logic                     busy,
  output logic [15:0]              sat_count,
  input  logic                     clear_stats
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic signed [47:0] OUT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
  localparam logic signed [47:0] OUT_MIN = -(48'sd1 <<< (OUT_W - 1));

  logic signed [MULT_W-1:0] mult_tbl  [N_CH];
  logic [SHIFT_W-1:0]       shift_tbl [N_CH];
  logic [CH_W-1:0]          ch_idx;

  logic adv, accept;

  logic                     s1_valid, s1_last;
  logic signed [31:0]       s1_acc;
  logic signed [MULT_W-1:0] s1_mult;
  logic [SHIFT_W-1:0]       s1_shift;

  logic                     s2_valid, s2_last;
  logic signed [47:0]       s2_prod;
  logic [SHIFT_W-1:0]       s2_shift;

  logic                     s3_valid, s3_last;
  logic signed [OUT_W-1:0]  s3_data;

  logic                     out_valid_q, out_last_q;
  logic signed [OUT_W-1:0]  out_data_q;

  logic [5:0]               sh_eff;
  logic signed [47:0]       rnd;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     clamp;

  assign adv          = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  assign busy = s1_valid | s2_valid | s3_valid | out_valid_q | (ch_idx != '0);

  // NOTE: the scale table is reset like any other control state because its
  // reset contents (mult=1, shift=0) are architecturally visible defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        mult_tbl[i]  <= MULT_W'(1);
        shift_tbl[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      cfg_err <= cfg_we && busy;
      if (cfg_we && !busy) begin
        mult_tbl[cfg_ch]  <= cfg_mult;
        shift_tbl[cfg_ch] <= cfg_shift;
      end
    end
  end

  // A vector closes either on in_last or when the table runs out of channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx <= '0;
    end else if (accept) begin
      if (bus.in_last || ch_idx == CH_W'(N_CH - 1)) ch_idx <= '0;
      else                                         ch_idx <= ch_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      s1_valid    <= accept;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      out_valid_q <= s3_valid;
      if (s3_valid) begin
        out_data_q <= s3_data;
        out_last_q <= s3_last;
      end
    end
  end

  // Datapath registers are qualified by the valids above, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_acc   <= bus.in_data;
      s1_mult  <= mult_tbl[ch_idx];
      s1_shift <= shift_tbl[ch_idx];
      s1_last  <= bus.in_last;
    end
    if (adv && s1_valid) begin
      s2_prod  <= 48'(s1_acc) * 48'(s1_mult);
      s2_shift <= s1_shift;
      s2_last  <= s1_last;
    end
    if (adv && s2_valid) begin
      s3_data <= sat_val;
      s3_last <= s2_last;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    sh_eff = (32'(s2_shift) > 32'd47) ? 6'd47 : 6'(s2_shift);
    rnd    = s2_prod;
    if (sh_eff != 6'd0)
      rnd = (s2_prod + (48'sd1 <<< (sh_eff - 6'd1))) >>> sh_eff;
    clamp   = 1'b0;
    sat_val = rnd[OUT_W-1:0];
    if (rnd > OUT_MAX) begin
      sat_val = OUT_MAX[OUT_W-1:0];
      clamp   = 1'b1;
    end else if (rnd < OUT_MIN) begin
      sat_val = OUT_MIN[OUT_W-1:0];
      clamp   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (clear_stats)
      sat_count <= '0;
    else if (adv && s2_valid && clamp && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_fxp_requant_ctrl.sv
// Directed bench for fxp_requant_ctrl: identity/saturation, rounding, per-channel scaling,
// backpressure, config rejection while busy, reset mid-stream and sat_count limits.
module tb_fxp_requant_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic signed [15:0] cfg_mult = '0;
  logic [5:0]  cfg_shift = '0;
  logic        cfg_err;
  logic        busy;
  logic [15:0] sat_count;
  logic        clear_stats = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int got_d[$];
  bit got_l[$];
  bit collect_en = 1'b1;

  fxp_requant_if #(.OUT_W(8)) bus ();

  fxp_requant_ctrl #(.N_CH(16), .OUT_W(8), .MULT_W(16), .SHIFT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mult    (cfg_mult),
    .cfg_shift   (cfg_shift),
    .cfg_err     (cfg_err),
    .bus         (bus.slave),
    .busy        (busy),
    .sat_count   (sat_count),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  // Record every output transfer; sampled on the falling edge before the transferring edge.
  always @(negedge clk) begin
    if (collect_en && rst_n && bus.out_valid && bus.out_ready) begin
      got_d.push_back(int'(bus.out_data));
      got_l.push_back(bus.out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic send(input int d, input bit l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic cfg_write(input string tag, input int ch, input int m, input int s, input bit exp_err);
    cfg_we    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_mult  = 16'(m);
    cfg_shift = 6'(s);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check(tag, 32'(cfg_err), 32'(exp_err));
    if (exp_err) begin
      @(negedge clk);
      check({tag, "_pulse_end"}, 32'(cfg_err), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input int d, input bit l);
    int  od = 32'hBAD0BAD0;
    bit  ol = 1'b0;
    if (got_d.size() > 0) begin
      od = got_d.pop_front();
      ol = got_l.pop_front();
    end
    check({tag, "_data"}, 32'(od), 32'(d));
    check({tag, "_last"}, 32'(ol), 32'(l));
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_sat_count", 32'(sat_count),     32'd0);
    check("rst_cfg_err",   32'(cfg_err),       32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Identity + saturation with latency: accept at edge k, out_valid after edge k+3.
    bus.in_valid = 1'b1;
    bus.in_data  = 100;
    @(posedge clk);
    #1 bus.in_data = 300;
    @(posedge clk);
    #1 begin bus.in_data = -300; bus.in_last = 1'b1; end
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.in_last = 1'b0; end
    @(negedge clk);
    check("lat_before_k3", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_at_k3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_at_k3_data",  32'(int'(bus.out_data)), 32'd100);
    wait_idle("ident");
    check("ident_count", 32'(got_d.size()), 32'd3);
    pop_check("ident0", 100, 1'b0);
    pop_check("ident1", 127, 1'b0);
    pop_check("ident2", -128, 1'b1);
    check("ident_sat_count", 32'(sat_count), 32'd2);
    pulse_clear();
    check("clear_stats", 32'(sat_count), 32'd0);

    // Round half up, arithmetic shift by 2.
    cfg_write("cfg_round", 0, 1, 2, 1'b0);
    send(6, 1'b1);
    send(5, 1'b1);
    send(-6, 1'b1);
    send(-7, 1'b1);
    wait_idle("round");
    pop_check("round_6", 2, 1'b1);
    pop_check("round_5", 1, 1'b1);
    pop_check("round_m6", -1, 1'b1);
    pop_check("round_m7", -2, 1'b1);

    // Per-channel scaling; a partial vector keeps busy high.
    cfg_write("cfg_ch0", 0, 3, 1, 1'b0);
    cfg_write("cfg_ch1", 1, -2, 0, 1'b0);
    send(10, 1'b0);
    repeat (8) @(negedge clk);
    check("partial_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send(10, 1'b1);
    wait_idle("chan");
    check("chan_idle_busy", 32'(busy), 32'd0);
    pop_check("chan0", 15, 1'b0);
    pop_check("chan1", -20, 1'b1);

    // Backpressure: 8 identity words with a 5-cycle output stall mid-stream.
    cfg_write("cfg_id0", 0, 1, 0, 1'b0);
    cfg_write("cfg_id1", 1, 1, 0, 1'b0);
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i * 3, i == 8);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 12; n++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(bus.in_ready),
                32'(!(bus.out_valid && !bus.out_ready)));
        end
      end
    join
    wait_idle("bp");
    check("bp_count", 32'(got_d.size()), 32'd8);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("bp%0d", i), i * 3, i == 8);

    // Config write while busy is dropped; same write while idle lands.
    send(50, 1'b1);
    cfg_write("cfg_busy_err", 0, 5, 0, 1'b1);
    wait_idle("cfgb");
    pop_check("cfgb_word", 50, 1'b1);
    send(7, 1'b1);
    wait_idle("cfgb_ro");
    pop_check("cfgb_unchanged", 7, 1'b1);
    cfg_write("cfg_idle_ok", 0, 5, 0, 1'b0);
    send(7, 1'b1);
    wait_idle("cfgi");
    pop_check("cfg_applied", 35, 1'b1);

    // Reset mid-stream with words in flight.
    send(1000, 1'b0);
    send(1000, 1'b0);
    send(1000, 1'b0);
    send(1000, 1'b0);
    check("pre_rst_sat", 32'(sat_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),          32'd0);
    check("mid_rst_sat",       32'(sat_count),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got_d.delete();
    got_l.delete();
    @(posedge clk);
    #1;
    send(7, 1'b1);
    wait_idle("post_rst");
    check("post_rst_count", 32'(got_d.size()), 32'd1);
    pop_check("post_rst_table", 7, 1'b1);

    // sat_count ceiling.
    collect_en   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 1000;
    bus.in_last  = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    send(1000, 1'b1);
    wait_idle("satmax");
    check("sat_ceiling", 32'(sat_count), 32'h0000FFFF);
    send(-1000, 1'b1);
    wait_idle("sathold");
    check("sat_hold", 32'(sat_count), 32'h0000FFFF);

    // Clear coinciding with a clamped S3 load: clear wins.
    pulse_clear();
    check("sat_cleared", 32'(sat_count), 32'd0);
    send(1000, 1'b1);
    @(posedge clk);
    #1 clear_stats = 1'b1;
    @(posedge clk);
    #1 clear_stats = 1'b0;
    @(negedge clk);
    check("clear_vs_inc", 32'(sat_count), 32'd0);
    wait_idle("clr");
    check("clear_vs_inc_final", 32'(sat_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
